aes_encipher_pblock: RTL and testbench

AES_ENCIPHER_PBLOCK -- requirements
Module: aes_encipher_pblock

---
 rtl/aes_encipher_pblock_if.sv | 37 +++
 rtl/aes_encipher_pblock.sv | 200 ++++++++++++++++++++
 tb/tb_aes_encipher_pblock.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encipher_pblock_if.sv
// ---------------------------------------------------------------------------
// aes_encipher_pblock_if
// Groups the control, key-memory, S-box and data signals of the AES
// encipher datapath into one bundle.
//   next, abort, keylen      : start/cancel requests and key length
//   round, round_key         : round index out, round key back in
//   sboxw, new_sboxw         : words to external S-boxes and their result
//   block, new_block         : plaintext in, state register out
//   ready, done              : idle flag and completion pulse
// master = the controlling side (key memory, S-boxes, host)
// slave  = the encipher block
// ---------------------------------------------------------------------------
interface aes_encipher_pblock_if #(
    parameter int unsigned SW = 32
);
    logic           next;
    logic           abort;
    logic [1:0]     keylen;
    logic [3:0]     round;
    logic [127:0]   round_key;
    logic [SW-1:0]  sboxw;
    logic [SW-1:0]  new_sboxw;
    logic [127:0]   block;
    logic [127:0]   new_block;
    logic           ready;
    logic           done;

    modport master (
        output next, abort, keylen, round_key, new_sboxw, block,
        input  round, sboxw, new_block, ready, done
    );

    modport slave (
        input  next, abort, keylen, round_key, new_sboxw, block,
        output round, sboxw, new_block, ready, done
    );
endinterface

// File: rtl/aes_encipher_pblock.sv
// ---------------------------------------------------------------------------
// aes_encipher_pblock
// Iterative AES encipher datapath. S-boxes and key expansion live outside:
// the block presents SBOX_WORDS state words per cycle on sboxw and writes
// the combinationally returned new_sboxw back; round_key is indexed by round.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : aes_encipher_pblock_if.slave (see interface file)
// ---------------------------------------------------------------------------
module aes_encipher_pblock #(
    parameter int unsigned SBOX_WORDS = 1,
    parameter int unsigned SW         = 32 * SBOX_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_encipher_pblock_if.slave bus
);

    localparam int unsigned SBOX_CYCLES = 4 / SBOX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic [127:0]   r_state;
    logic [127:0]   w_state_next;
    logic [3:0]     r_round;
    logic [3:0]     w_round_next;
    logic [3:0]     r_nr;
    logic [3:0]     w_nr_next;
    logic [1:0]     r_wcnt;
    logic [1:0]     w_wcnt_next;
    logic           r_ready;
    logic           w_ready_next;
    logic           r_done;
    logic           w_done_next;
    logic [SW-1:0]  w_sboxw;
    logic           w_last_sbox;

    // ---------------- GF(2^8) helpers --------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]),
                mix_word(s[63:32]),  mix_word(s[31:0])};
    endfunction

    // Row r of column c moves from column (c + r) mod 4; each word is a
    // column with row 0 in its top byte.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    // ---------------- S-box port ------------------------------------------
    assign w_last_sbox = (r_wcnt == 2'(SBOX_CYCLES - 1));

    always_comb begin
        w_sboxw = '0;
        if (r_fsm == SBOX) begin
            for (int unsigned i = 0; i < SBOX_WORDS; i++) begin
                w_sboxw[SW - 1 - 32*i -: 32] =
                    r_state[127 - 32*(r_wcnt*SBOX_WORDS + i) -: 32];
            end
        end
    end

    // ---------------- next-state / datapath -------------------------------
    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_round_next = r_round;
        w_nr_next    = r_nr;
        w_wcnt_next  = r_wcnt;
        w_ready_next = r_ready;
        w_done_next  = 1'b0;

        case (r_fsm)
            IDLE: begin
                if (bus.next) begin
                    w_round_next = 4'd0;
                    case (bus.keylen)
                        2'd1:    w_nr_next = 4'd12;
                        2'd2:    w_nr_next = 4'd14;
                        default: w_nr_next = 4'd10;
                    endcase
                    w_ready_next = 1'b0;
                    w_fsm_next   = INIT;
                end
            end

            INIT: begin
                if (bus.abort) begin
                    w_ready_next = 1'b1;
                    w_fsm_next   = IDLE;
                end else begin
                    w_state_next = bus.block ^ bus.round_key;
                    w_round_next = 4'd1;
                    w_wcnt_next  = 2'd0;
                    w_fsm_next   = SBOX;
                end
            end

            SBOX: begin
                if (bus.abort) begin
                    w_ready_next = 1'b1;
                    w_fsm_next   = IDLE;
                end else begin
                    for (int unsigned i = 0; i < SBOX_WORDS; i++) begin
                        w_state_next[127 - 32*(r_wcnt*SBOX_WORDS + i) -: 32] =
                            bus.new_sboxw[SW - 1 - 32*i -: 32];
                    end
                    if (w_last_sbox) begin
                        w_wcnt_next = 2'd0;
                        w_fsm_next  = MAIN;
                    end else begin
                        w_wcnt_next = r_wcnt + 2'd1;
                    end
                end
            end

            MAIN: begin
                if (bus.abort) begin
                    w_ready_next = 1'b1;
                    w_fsm_next   = IDLE;
                end else if (r_round < r_nr) begin
                    w_state_next = mix_columns(shift_rows(r_state)) ^ bus.round_key;
                    w_round_next = r_round + 4'd1;
                    w_wcnt_next  = 2'd0;
                    w_fsm_next   = SBOX;
                end else begin
                    w_state_next = shift_rows(r_state) ^ bus.round_key;
                    w_ready_next = 1'b1;
                    w_done_next  = 1'b1;
                    w_fsm_next   = IDLE;
                end
            end

            default: begin
                w_fsm_next = IDLE;
            end
        endcase
    end

    // ---------------- registers -------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_round <= '0;
            r_nr    <= 4'd10;
            r_wcnt  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_nr    <= w_nr_next;
            r_wcnt  <= w_wcnt_next;
            r_ready <= w_ready_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.round     = r_round;
    assign bus.sboxw     = w_sboxw;
    assign bus.new_block = r_state;
    assign bus.ready     = r_ready;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_aes_encipher_pblock.sv
// ---------------------------------------------------------------------------
// tb_aes_encipher_pblock
// Three instances (SBOX_WORDS = 1, 2, 4) share stimulus; t_sel picks which
// one sees next/abort. The bench supplies S-boxes and round keys and keeps
// its own byte-matrix AES model for randomized checking.
// ---------------------------------------------------------------------------
module tb_aes_encipher_pblock;

    logic         clk = 1'b0;
    logic         t_reset;
    logic         t_next;
    logic         t_abort;
    logic [1:0]   t_keylen;
    logic [127:0] t_block;
    logic [2:0]   t_sel;

    logic [127:0] rk [16];

    logic [127:0] d_nb    [3];
    logic [3:0]   d_round [3];
    logic [2:0]   d_ready;
    logic [2:0]   d_done;
    logic [2:0]   d_sbz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ---------------- behavioural S-box ------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin   // x^254 = prod x^(2^k), k=1..7
            t   = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    endfunction

    // ---------------- key expansion into rk[] ------------------------------
    task automatic set_key(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        int nr;
        nr   = nr_of(kl);
        nk   = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // ---------------- reference cipher on a 4x4 byte matrix ----------------
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ rk[0][127 - 8*(r + 4*c) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox(s[r][(c + r) % 4]);
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rd < nr)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ rk[rd][127 - 8*(r + 4*c) -: 8];
                end
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- DUT instances ----------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned SWD = 1 << g;

        aes_encipher_pblock_if #(.SW(32 * SWD)) bus ();

        assign bus.next      = t_next  & t_sel[g];
        assign bus.abort     = t_abort & t_sel[g];
        assign bus.keylen    = t_keylen;
        assign bus.block     = t_block;
        assign bus.round_key = rk[bus.round];

        always_comb begin
            bus.new_sboxw = '0;
            for (int unsigned i = 0; i < SWD; i++)
                bus.new_sboxw[32*i +: 32] = subword(bus.sboxw[32*i +: 32]);
        end

        aes_encipher_pblock #(.SBOX_WORDS(SWD)) dut (
            .clk   (clk),
            .reset (t_reset),
            .bus   (bus)
        );

        assign d_nb[g]    = bus.new_block;
        assign d_round[g] = bus.round;
        assign d_ready[g] = bus.ready;
        assign d_done[g]  = bus.done;
        assign d_sbz[g]   = |bus.sboxw;
    end

    // ---------------- checking helpers -------------------------------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode bit0: toggle keylen while busy; bit1: pulse next while busy;
    // bit2: hold abort together with next in the start cycle.
    task automatic run_op(input int j, input logic [1:0] kl, input logic [127:0] pt,
                          input int mode, output int cycles, output int ndone,
                          output logic [127:0] ct, output logic [3:0] rnd,
                          output logic held);
        @(negedge clk);
        t_sel    = 3'(1 << j);
        t_keylen = kl;
        t_block  = pt;
        t_next   = 1'b1;
        t_abort  = ((mode & 4) != 0);
        cycles   = 0;
        ndone    = 0;
        while (ndone == 0 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            t_abort = 1'b0;
            if (d_done[j]) begin
                ndone  = 1;
                t_next = 1'b0;
            end else begin
                t_next = ((mode & 2) != 0) && (cycles % 5 == 2);
                if ((mode & 1) != 0) t_keylen = t_keylen ^ 2'b01;
            end
        end
        t_next = 1'b0;
        ct     = d_nb[j];
        rnd    = d_round[j];
        held   = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (d_done[j]) ndone++;
            if (d_nb[j] !== ct || !d_ready[j] || d_sbz[j]) held = 1'b0;
        end
    endtask

    typedef struct {
        int           inst;
        logic [1:0]   kl;
        logic [127:0] ct;
        int           cyc;
        int           nr;
        int           mode;
    } vec_t;

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        vec_t         vt [9];
        int           cycles;
        int           ndone;
        int           found;
        int           exp_cyc;
        logic [127:0] ct;
        logic [127:0] saved;
        logic [127:0] exp_ct;
        logic [3:0]   rnd;
        logic         held;
        logic         bad;

        vt[0] = '{0, 2'd0, CT128, 52, 10, 0};
        vt[1] = '{1, 2'd0, CT128, 32, 10, 0};
        vt[2] = '{2, 2'd0, CT128, 22, 10, 0};
        vt[3] = '{0, 2'd1, CT192, 62, 12, 0};
        vt[4] = '{0, 2'd2, CT256, 72, 14, 0};
        vt[5] = '{2, 2'd3, CT128, 22, 10, 0};
        vt[6] = '{1, 2'd0, CT128, 32, 10, 1};
        vt[7] = '{0, 2'd0, CT128, 52, 10, 2};
        vt[8] = '{2, 2'd0, CT128, 22, 10, 4};

        t_reset  = 1'b1;
        t_next   = 1'b0;
        t_abort  = 1'b0;
        t_keylen = 2'd0;
        t_block  = '0;
        t_sel    = 3'b000;
        set_key(KEY, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        t_reset = 1'b0;

        // reset state of every instance
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst_nb%0d", j),    d_nb[j],    128'h0);
            chk($sformatf("rst_round%0d", j), 128'(d_round[j]), 128'h0);
            chk($sformatf("rst_ready%0d", j), 128'(d_ready[j]), 128'h1);
            chk($sformatf("rst_done%0d", j),  128'(d_done[j]),  128'h0);
            chk($sformatf("rst_sbox%0d", j),  128'(d_sbz[j]),   128'h0);
        end

        // known-answer vectors
        for (int v = 0; v < 9; v++) begin
            set_key(KEY, vt[v].kl);
            run_op(vt[v].inst, vt[v].kl, PT, vt[v].mode, cycles, ndone, ct, rnd, held);
            chk($sformatf("vec%0d_ct", v),    ct, vt[v].ct);
            chk($sformatf("vec%0d_cyc", v),   128'(cycles), 128'(vt[v].cyc));
            chk($sformatf("vec%0d_ndone", v), 128'(ndone), 128'h1);
            chk($sformatf("vec%0d_round", v), 128'(rnd), 128'(vt[v].nr));
            chk($sformatf("vec%0d_hold", v),  128'(held), 128'h1);
        end

        // abort alone in IDLE does nothing
        saved = d_nb[0];
        @(negedge clk);
        t_sel   = 3'b001;
        t_abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        t_abort = 1'b0;
        chk("idle_abort_ready", 128'(d_ready[0]), 128'h1);
        chk("idle_abort_nb",    d_nb[0], saved);

        // abort during round 5 S-box phase (SBOX_WORDS=1)
        set_key(KEY, 2'd0);
        @(negedge clk);
        t_sel    = 3'b001;
        t_keylen = 2'd0;
        t_block  = PT;
        t_next   = 1'b1;
        found    = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(posedge clk);
            #1;
            t_next = 1'b0;
            if (d_round[0] == 4'd5 && !d_ready[0]) found = 1;
        end
        chk("abort_reached_r5", 128'(found), 128'h1);
        t_abort = 1'b1;
        @(posedge clk);
        #1;
        t_abort = 1'b0;
        chk("abort_ready", 128'(d_ready[0]), 128'h1);
        chk("abort_done",  128'(d_done[0]),  128'h0);
        saved = d_nb[0];
        bad   = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (d_done[0] || !d_ready[0] || d_nb[0] !== saved) bad = 1'b1;
        end
        chk("abort_quiet", 128'(bad), 128'h0);
        run_op(0, 2'd0, PT, 0, cycles, ndone, ct, rnd, held);
        chk("post_abort_ct",  ct, CT128);
        chk("post_abort_cyc", 128'(cycles), 128'd52);

        // reset in the MAIN cycle of round 3 (SBOX_WORDS=4)
        @(negedge clk);
        t_sel  = 3'b100;
        t_next = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            t_next = 1'b0;
        end
        t_reset = 1'b1;
        @(posedge clk);
        #1;
        t_reset = 1'b0;
        chk("midrst_nb",    d_nb[2], 128'h0);
        chk("midrst_round", 128'(d_round[2]), 128'h0);
        chk("midrst_ready", 128'(d_ready[2]), 128'h1);
        chk("midrst_done",  128'(d_done[2]),  128'h0);
        chk("midrst_sbox",  128'(d_sbz[2]),   128'h0);

        // randomized operations against the byte-matrix model
        for (int n = 0; n < 24; n++) begin
            int           j;
            logic [1:0]   kl;
            logic [255:0] key;
            logic [127:0] pt;
            j  = $urandom_range(0, 2);
            kl = 2'($urandom_range(0, 3));
            for (int b = 0; b < 8; b++) key[32*b +: 32] = $urandom;
            for (int b = 0; b < 4; b++) pt[32*b +: 32] = $urandom;
            set_key(key, kl);
            exp_ct  = ref_encrypt(pt, nr_of(kl));
            exp_cyc = 2 + nr_of(kl) * ((4 >> j) + 1);
            run_op(j, kl, pt, 0, cycles, ndone, ct, rnd, held);
            chk($sformatf("rnd%0d_ct", n),    ct, exp_ct);
            chk($sformatf("rnd%0d_cyc", n),   128'(cycles), 128'(exp_cyc));
            chk($sformatf("rnd%0d_ndone", n), 128'(ndone), 128'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
